serial_add_ctrl: RTL and testbench

Bit-serial add/subtract controller that time-shares a single full_adder cell (a, b, c -> sum, carry) across all bits of a WIDTH-bit operand pair, LSB first, one bit per clock. It owns operand/result shift registers, the carry flop, the bit counter and a start/busy/done handshake. It is the low-area arithmetic unit for control-path datapaths where latency is not critical.

---
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller.
// A single full-adder cell is time-shared across all WIDTH bits, LSB first,
// one bit per clock. Subtraction is done as op_a + ~op_b + 1.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request an operation (accepted only when idle)
//   sub       0: op_a + op_b, 1: op_a - op_b (sampled with start)
//   op_a/op_b WIDTH-bit operands (sampled with start)
//   busy      high while an operation is running or completing
//   done      one-cycle pulse, result and flags valid from this cycle
//   result    WIDTH-bit sum/difference, held until the next accepted start
//   carry_out final carry; for sub, 1 means no borrow
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  // Shared full-adder cell
  logic fa_a, fa_b, fa_c, fa_sum, fa_carry;
  assign fa_a     = sh_a_q[0];
  assign fa_b     = sh_b_q[0];
  assign fa_c     = carry_q;
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

  logic last_bit;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_a_d      = op_a;
          sh_b_d      = sub ? ~op_b : op_b;
          carry_d     = sub;  // the +1 of two's complement negation
          cnt_d       = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          state_d     = StRun;
        end
      end
      StRun: begin
        sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // carry_q is still the carry into the MSB here
          carry_out_d = fa_carry;
          overflow_d  = fa_carry ^ carry_q;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed checks on an 8-bit instance plus
// random back-to-back operations on 8-, 2- and 32-bit instances.
module tb_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sub;
  logic [2:0]  start_v;
  logic [31:0] op_a, op_b;

  logic [2:0]  busy_v, done_v, co_v, ov_v;
  logic [7:0]  res8;
  logic [1:0]  res2;
  logic [31:0] res32;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub),
    .op_a(op_a[7:0]), .op_b(op_b[7:0]), .busy(busy_v[0]), .done(done_v[0]),
    .result(res8), .carry_out(co_v[0]), .overflow(ov_v[0])
  );

  serial_add_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub),
    .op_a(op_a[1:0]), .op_b(op_b[1:0]), .busy(busy_v[1]), .done(done_v[1]),
    .result(res2), .carry_out(co_v[1]), .overflow(ov_v[1])
  );

  serial_add_ctrl #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub),
    .op_a(op_a), .op_b(op_b), .busy(busy_v[2]), .done(done_v[2]),
    .result(res32), .carry_out(co_v[2]), .overflow(ov_v[2])
  );

  function automatic logic [31:0] res_of(input int idx);
    case (idx)
      0:       return {24'd0, res8};
      1:       return {30'd0, res2};
      default: return res32;
    endcase
  endfunction

  // One operation on instance idx. Waits for idle, pulses start for one edge,
  // then scrambles the inputs (they must no longer matter). lat counts edges
  // after the accepting edge until done is seen; bcnt counts busy samples
  // from the accepting edge through the done sample.
  task automatic run_op(input int idx, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic co, output logic ov,
                        output int lat, output int bcnt, output bit ok);
    int guard = 0;
    while (busy_v[idx] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    sub = s; op_a = a; op_b = b; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = ~s;
    lat = 0; ok = 1'b0; r = '0; co = 1'b0; ov = 1'b0;
    bcnt = busy_v[idx] ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy_v[idx]) bcnt++;
      if (done_v[idx]) begin
        lat = k; ok = 1'b1;
        r = res_of(idx); co = co_v[idx]; ov = ov_v[idx];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_v = '0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy_v[0], done_v[0], co_v[0], ov_v[0], res8} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset8: busy/done/co/ov/result=%b/%b/%b/%b/%h required all 0",
               busy_v[0], done_v[0], co_v[0], ov_v[0], res8);
    end
    n_tests++;
    if ({busy_v, done_v, co_v[2:1], ov_v[2:1], res2, res32} !== '0) begin
      n_fail++;
      $display("FAIL reset2_32: outputs not zero, res2=%h res32=%h", res2, res32);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic        s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0]  a [6] = '{8'h3C, 8'hFF, 8'h7F, 8'h10, 8'h80, 8'h55};
    logic [7:0]  b [6] = '{8'h25, 8'h01, 8'h01, 8'h20, 8'h01, 8'h55};
    logic [7:0]  er[6] = '{8'h61, 8'h00, 8'h80, 8'hF0, 8'h7F, 8'h00};
    logic        ec[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        eo[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] r;
    logic        co, ov;
    int          lat, bcnt;
    bit          ok;
    for (int i = 0; i < 6; i++) begin
      run_op(0, s[i], {24'd0, a[i]}, {24'd0, b[i]}, r, co, ov, lat, bcnt, ok);
      n_tests++;
      if (!ok || {r[7:0], co, ov} !== {er[i], ec[i], eo[i]}) begin
        n_fail++;
        $display("FAIL vec%0d: done=%0b result=%h co=%b ov=%b required result=%h co=%b ov=%b",
                 i, ok, r[7:0], co, ov, er[i], ec[i], eo[i]);
      end
      if (i == 0) begin
        // done appears in the cycle after edge T+8 (seen at edge T+9)
        n_tests++;
        if (lat !== 8) begin
          n_fail++;
          $display("FAIL latency: edges=%0d required 8", lat);
        end
        n_tests++;
        if (bcnt !== 9) begin
          n_fail++;
          $display("FAIL busy_cycles: got %0d required 9", bcnt);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({done_v[0], busy_v[0], res8, co_v[0], ov_v[0]} !== {1'b0, 1'b0, 8'h61, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL done_width_hold: done=%b busy=%b result=%h required 0/0/61",
                   done_v[0], busy_v[0], res8);
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int          dones = 0;
    logic [7:0]  r = '0;
    logic        co = 1'b1, ov = 1'b1;
    while (busy_v[0]) begin @(posedge clk); #1; end
    sub = 1'b0; op_a = 32'h12; op_b = 32'h34; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start_v[0] = (k == 3 || k == 8);
      if (start_v[0]) begin
        sub = 1'b1; op_a = 32'hAA; op_b = 32'h0F;
      end
      if (done_v[0]) begin
        dones++;
        r = res8; co = co_v[0]; ov = ov_v[0];
      end
    end
    start_v[0] = 1'b0;
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL ignore_start_dones: got %0d required 1", dones);
    end
    n_tests++;
    if ({r, co, ov} !== {8'h46, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ignore_start_result: result=%h co=%b ov=%b required 46/0/0", r, co, ov);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic        co, ov;
    int          lat, bcnt;
    bit          ok;
    logic        b1, b2;
    run_op(0, 1'b0, 32'h3C, 32'h25, r, co, ov, lat, bcnt, ok);
    // hold start from the done cycle: ignored at the DONE edge, taken next
    sub = 1'b1; op_a = 32'h20; op_b = 32'h05; start_v[0] = 1'b1;
    @(posedge clk); #1;
    b1 = busy_v[0];
    @(posedge clk); #1;
    b2 = busy_v[0];
    start_v[0] = 1'b0;
    n_tests++;
    if ({ok, b1, b2} !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_accept: done=%b busy_after_done_edge=%b busy_next=%b required 1/0/1",
               ok, b1, b2);
    end
    ok = 1'b0;
    for (int k = 1; k <= 20 && !ok; k++) begin
      @(posedge clk); #1;
      if (done_v[0]) ok = 1'b1;
    end
    n_tests++;
    if (!ok || {res8, co_v[0], ov_v[0]} !== {8'h1B, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_result: done=%b result=%h co=%b ov=%b required 1B/1/0",
               ok, res8, co_v[0], ov_v[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int          dones = 0;
    logic [31:0] r;
    logic        co, ov;
    int          lat, bcnt;
    bit          ok;
    while (busy_v[0]) begin @(posedge clk); #1; end
    sub = 1'b0; op_a = 32'h11; op_b = 32'h22; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    if ({busy_v[0], done_v[0], co_v[0], ov_v[0], res8} !== 12'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy/done/co/ov/result=%b/%b/%b/%b/%h required all 0",
               busy_v[0], done_v[0], co_v[0], ov_v[0], res8);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midrun_no_done: %0d busy/done cycles after reset, required 0", dones);
    end
    run_op(0, 1'b0, 32'h11, 32'h22, r, co, ov, lat, bcnt, ok);
    n_tests++;
    if (!ok || {r[7:0], co, ov} !== {8'h33, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_recover: done=%b result=%h co=%b ov=%b required 33/0/0",
               ok, r[7:0], co, ov);
    end
  endtask

  task automatic test_random(input int idx, input int w, input int n);
    logic [63:0] mask, am, bm, full, er;
    logic        ec, eo, sa, sb, sr, s;
    logic [31:0] a, b, r;
    logic        co, ov;
    int          lat, bcnt;
    bit          ok;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      am = {32'd0, a} & mask;
      bm = {32'd0, b} & mask;
      full = s ? am + ((~bm) & mask) + 64'd1 : am + bm;
      er = full & mask;
      ec = full[w];
      sa = am[w-1]; sb = bm[w-1]; sr = er[w-1];
      eo = s ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
      run_op(idx, s, a, b, r, co, ov, lat, bcnt, ok);
      n_tests++;
      if (!ok || {32'd0, r} !== er || co !== ec || ov !== eo || lat !== w) begin
        n_fail++;
        $display("FAIL rand_w%0d #%0d: s=%b a=%h b=%h got r=%h co=%b ov=%b lat=%0d required r=%h co=%b ov=%b lat=%0d",
                 w, i, s, am, bm, r, co, ov, lat, er, ec, eo, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random(0, 8, 1000);
    test_random(1, 2, 1000);
    test_random(2, 32, 1000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
